hue_pwm_sequencer: RTL and testbench

//   Parametrised successor to the discrete six-colour cycler for the RGB LED.

---
 rtl/hue_pwm_sequencer_if.sv | 29 ++
 rtl/hue_pwm_sequencer.sv | 136 +++++++++++++
 tb/tb_hue_pwm_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hue_pwm_sequencer_if.sv
// Control inputs and LED/status outputs of the hue PWM sequencer.
// The brightness signal exists only when HUE_BRIGHTNESS_EN is defined.
interface hue_pwm_sequencer_if #(
  parameter int PWM_BITS = 8
);
  logic                run;
  logic                dir;
  logic                step;
`ifdef HUE_BRIGHTNESS_EN
  logic [PWM_BITS-1:0] brightness;
`endif
  logic                red;
  logic                green;
  logic                blue;
  logic [2:0]          segment;
  logic                wrap;

`ifdef HUE_BRIGHTNESS_EN
  modport master (output run, dir, step, brightness,
                  input  red, green, blue, segment, wrap);
  modport slave  (input  run, dir, step, brightness,
                  output red, green, blue, segment, wrap);
`else
  modport master (output run, dir, step,
                  input  red, green, blue, segment, wrap);
  modport slave  (input  run, dir, step,
                  output red, green, blue, segment, wrap);
`endif
endinterface

// File: rtl/hue_pwm_sequencer.sv
// Continuous colour-wheel fader driving RGB PWM pins with run/step/direction control.
// Define HUE_BRIGHTNESS_EN to add a global brightness scale applied at each period boundary.
module hue_pwm_sequencer #(
  parameter int PWM_BITS      = 8,
  parameter int STEP_INTERVAL = 7812
) (
  input logic                clk,
  input logic                rst_n,
  hue_pwm_sequencer_if.slave bus
);
  localparam logic [PWM_BITS-1:0] MAX    = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_TC = MAX - 1'b1;
  localparam int                  PRE_W  = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [PRE_W-1:0]    PRE_TC = PRE_W'(STEP_INTERVAL - 1);

  logic [2:0]          seg, seg_nxt;
  logic [PWM_BITS-1:0] lvl, lvl_nxt;
  logic                wrap_nxt;
  logic [PRE_W-1:0]    prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
  logic [PWM_BITS-1:0] map_r, map_g, map_b;
  logic [PWM_BITS-1:0] load_r, load_g, load_b;
  logic                advance;
  logic                period_end;

  // A step pulse coinciding with the prescaler terminal count still yields a single advance.
  assign advance    = (bus.run && (prescaler == PRE_TC)) || bus.step;
  assign period_end = (pwm_cnt == PWM_TC);

  always_comb begin
    seg_nxt  = seg;
    lvl_nxt  = lvl;
    wrap_nxt = 1'b0;
    if (seg > 3'd5) begin
      seg_nxt = 3'd0;
      lvl_nxt = '0;
    end else if (advance) begin
      if (!bus.dir) begin
        if (lvl == MAX) begin
          lvl_nxt = '0;
          if (seg == 3'd5) begin
            seg_nxt  = 3'd0;
            wrap_nxt = 1'b1;
          end else begin
            seg_nxt = seg + 3'd1;
          end
        end else begin
          lvl_nxt = lvl + 1'b1;
        end
      end else begin
        if (lvl == '0) begin
          lvl_nxt = MAX;
          if (seg == 3'd0) begin
            seg_nxt  = 3'd5;
            wrap_nxt = 1'b1;
          end else begin
            seg_nxt = seg - 3'd1;
          end
        end else begin
          lvl_nxt = lvl - 1'b1;
        end
      end
    end
  end

  always_comb begin
    map_r = '0;
    map_g = '0;
    map_b = '0;
    case (seg)
      3'd0: begin map_r = MAX;       map_g = lvl;       end
      3'd1: begin map_r = MAX - lvl; map_g = MAX;       end
      3'd2: begin map_g = MAX;       map_b = lvl;       end
      3'd3: begin map_g = MAX - lvl; map_b = MAX;       end
      3'd4: begin map_r = lvl;       map_b = MAX;       end
      3'd5: begin map_r = MAX;       map_b = MAX - lvl; end
      default: ;
    endcase
  end

`ifdef HUE_BRIGHTNESS_EN
  localparam int PROD_W = 2 * PWM_BITS + 1;

  // brightness+1 makes full scale an exact pass-through and zero fully dark.
  function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] duty,
                                                input logic [PWM_BITS-1:0] bright);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(duty) * (PROD_W'(bright) + PROD_W'(1));
    return PWM_BITS'(prod >> PWM_BITS);
  endfunction

  assign load_r = scale(map_r, bus.brightness);
  assign load_g = scale(map_g, bus.brightness);
  assign load_b = scale(map_b, bus.brightness);
`else
  assign load_r = map_r;
  assign load_g = map_g;
  assign load_b = map_b;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg       <= 3'd0;
      lvl       <= '0;
      prescaler <= '0;
      pwm_cnt   <= '0;
      duty_r    <= MAX;
      duty_g    <= '0;
      duty_b    <= '0;
      bus.red   <= 1'b0;
      bus.green <= 1'b0;
      bus.blue  <= 1'b0;
      bus.wrap  <= 1'b0;
    end else begin
      seg      <= seg_nxt;
      lvl      <= lvl_nxt;
      bus.wrap <= wrap_nxt;
      if (bus.run) begin
        prescaler <= (prescaler == PRE_TC) ? '0 : prescaler + 1'b1;
      end
      pwm_cnt <= period_end ? '0 : pwm_cnt + 1'b1;
      if (period_end) begin
        duty_r <= load_r;
        duty_g <= load_g;
        duty_b <= load_b;
      end
      bus.red   <= (pwm_cnt < duty_r);
      bus.green <= (pwm_cnt < duty_g);
      bus.blue  <= (pwm_cnt < duty_b);
    end
  end

  assign bus.segment = seg;

endmodule

// File: tb/tb_hue_pwm_sequencer.sv
// Scoreboard bench for hue_pwm_sequencer: a wheel-position reference model queues the
// expected pins/status every cycle and an independent monitor compares them.
`timescale 1ns/1ps
module tb_hue_pwm_sequencer;
  localparam int PWM_BITS      = 4;
  localparam int STEP_INTERVAL = 3;
  localparam int MAX           = 15;
  localparam int SEG_LEN       = MAX + 1;
  localparam int NPOS          = 6 * SEG_LEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hue_pwm_sequencer_if #(.PWM_BITS(PWM_BITS)) bus ();

  hue_pwm_sequencer #(
    .PWM_BITS      (PWM_BITS),
    .STEP_INTERVAL (STEP_INTERVAL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       r;
    logic       g;
    logic       b;
    logic [2:0] seg;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: hue as a position 0..NPOS-1 on the wheel, PWM as time-in-period.
  int pos   = 0;
  int presc = 0;
  int t     = 0;
  int d_r   = MAX;
  int d_g   = 0;
  int d_b   = 0;

  function automatic void wheel(input int p, output int r, output int g, output int b);
    int s;
    int l;
    s = p / SEG_LEN;
    l = p % SEG_LEN;
    r = 0; g = 0; b = 0;
    case (s)
      0: begin r = MAX;     g = l;       b = 0;       end
      1: begin r = MAX - l; g = MAX;     b = 0;       end
      2: begin r = 0;       g = MAX;     b = l;       end
      3: begin r = 0;       g = MAX - l; b = MAX;     end
      4: begin r = l;       g = 0;       b = MAX;     end
      default: begin r = MAX; g = 0;     b = MAX - l; end
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin : model
    exp_t e;
    int   nr, ng, nb, br;
    bit   adv;
    e = '0;
    if (!rst_n) begin
      pos = 0; presc = 0; t = 0;
      d_r = MAX; d_g = 0; d_b = 0;
    end else begin
      e.r = (t < d_r);
      e.g = (t < d_g);
      e.b = (t < d_b);
      if (t == MAX - 1) begin
        wheel(pos, nr, ng, nb);
        br = MAX;
`ifdef HUE_BRIGHTNESS_EN
        br = int'(bus.brightness);
`endif
        d_r = nr * (br + 1) / SEG_LEN;
        d_g = ng * (br + 1) / SEG_LEN;
        d_b = nb * (br + 1) / SEG_LEN;
      end
      t = (t + 1) % MAX;
      adv = (bus.run && presc == STEP_INTERVAL - 1) || bus.step;
      if (bus.run) presc = (presc + 1) % STEP_INTERVAL;
      if (adv) begin
        if (!bus.dir) begin
          e.wrap = (pos == NPOS - 1);
          pos    = (pos + 1) % NPOS;
        end else begin
          e.wrap = (pos == 0);
          pos    = (pos + NPOS - 1) % NPOS;
        end
      end
      e.seg = 3'(pos / SEG_LEN);
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if ($time > 5) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_nonempty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("red",     int'(bus.red),     int'(e.r));
        check("green",   int'(bus.green),   int'(e.g));
        check("blue",    int'(bus.blue),    int'(e.b));
        check("segment", int'(bus.segment), int'(e.seg));
        check("wrap",    int'(bus.wrap),    int'(e.wrap));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.step = 1'($urandom_range(0, 1));
      bus.run  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rst_n    = 1'b1;
    bus.step = 1'b0;
    bus.run  = 1'b0;
  endtask

  initial begin : stimulus
    int n;
    bus.run  = 1'b0;
    bus.dir  = 1'b0;
    bus.step = 1'b0;
`ifdef HUE_BRIGHTNESS_EN
    bus.brightness = 4'(MAX);
`endif
    // Power-on reset with junk on the inputs, then idle: red steady, others dark.
    do_reset(3);
    bus.dir = 1'b0;
    cyc(40);

    // Forward run through a full wheel and the 5->0 wrap.
    bus.run = 1'b1;
    cyc(330);

    // Reverse single step from reset: 0 -> seg5/lvl15 with wrap.
    do_reset(2);
    bus.dir = 1'b1;
    cyc(5);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    cyc(40);

    // Reverse run with random step pulses, some landing on the terminal count.
    bus.run = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.step = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    bus.step = 1'b0;

    // Mid-operation single-cycle reset while in segment 3.
    do_reset(1);
    bus.dir = 1'b0;
    bus.run = 1'b1;
    n = 0;
    while ((pos / SEG_LEN) != 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("seg3_reached", int'(n < 400), 1);
    cyc(2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(40);

`ifdef HUE_BRIGHTNESS_EN
    // Brightness scaling at the reset hue: 7 -> half duty, 15 -> full, 0 -> dark.
    do_reset(2);
    bus.brightness = 4'd7;
    cyc(60);
    bus.brightness = 4'd15;
    cyc(45);
    bus.brightness = 4'd0;
    cyc(45);
`endif

    // Random mix of run/dir/step (and brightness), with rare resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1);
      end
      if ($urandom_range(0, 99) == 0) bus.dir = ~bus.dir;
      bus.run  = ($urandom_range(0, 7) != 0);
      bus.step = ($urandom_range(0, 7) == 0);
`ifdef HUE_BRIGHTNESS_EN
      if ($urandom_range(0, 49) == 0) bus.brightness = 4'($urandom_range(0, MAX));
`endif
      @(negedge clk);
    end
    bus.step = 1'b0;
    cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
